// File: rtl/counter_cap_pkg.sv
// Shared definitions for the counter timestamp capture block: edge-select
// encoding, default counter width and the edge-match helper.
package counter_cap_pkg;

    localparam int CNT_W_DEF = 32;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // True when the selected edge type(s) include an edge seen this cycle.
    function automatic logic edge_match(input logic [1:0] sel,
                                        input logic       rise,
                                        input logic       fall);
        logic want_rise;
        logic want_fall;
        want_rise = (sel == EDGE_RISE) || (sel == EDGE_BOTH);
        want_fall = (sel == EDGE_FALL) || (sel == EDGE_BOTH);
        return (want_rise && rise) || (want_fall && fall);
    endfunction

endpackage

// File: rtl/counter_capture_fifo_if.sv
// Valid/ready drain interface carrying captured timestamps from the capture
// block (master) to the consuming host logic (slave).
interface counter_capture_fifo_if
    import counter_cap_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             cap_valid;
    logic             cap_ready;
    logic [CNT_W-1:0] cap_data;

    modport master (
        output cap_valid,
        output cap_data,
        input  cap_ready
    );

    modport slave (
        input  cap_valid,
        input  cap_data,
        output cap_ready
    );

endinterface

// File: rtl/cap_sync_fifo.sv
// Single-clock DEPTH x WIDTH FIFO with registered head output; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module cap_sync_fifo
    import counter_cap_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);

    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Pointers are exactly log2(DEPTH) bits wide, so increment wraps modulo DEPTH.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/counter_capture_fifo.sv
// Timestamps edges of an asynchronous event line with the free-running counter
// value and buffers them for a valid/ready consumer, flagging dropped captures.
module counter_capture_fifo
    import counter_cap_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   p_reset,
    input  logic [CNT_W-1:0]       cnt_in,
    input  logic                   evt_in,
    input  logic [1:0]             edge_sel,
    counter_capture_fifo_if.master cap,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   ovf_sticky,
    input  logic                   ovf_clr
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic [ARM_W-1:0]       arm_q;
    logic [ARM_W-1:0]       arm_d;
    logic                   ovf_q;
    logic                   ovf_d;

    logic             s;
    logic             rise;
    logic             fall;
    logic             armed;
    logic             det;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] head;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], evt_in};
        s      = sync_q[SYNC_STAGES-1];
        rise   = s && !prev_q;
        fall   = !s && prev_q;
        // Edges are ignored until the chain has been refilled with real samples after reset.
        armed  = (arm_q == ARM_W'(ARM_MAX));
        arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
        det    = armed && !p_reset && edge_match(edge_sel, rise, fall);
        pop    = !empty && cap.cap_ready;
        push   = det && (!full || pop);
        drop   = det && full && !pop;
        ovf_d  = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (p_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= s;
            arm_q  <= arm_d;
            ovf_q  <= ovf_d;
        end
    end

    cap_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (p_reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (cnt_in),
        .rdata_o (head),
        .level_o (fifo_level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign cap.cap_valid = !empty;
    assign cap.cap_data  = head;
    assign ovf_sticky    = ovf_q;

endmodule

// File: tb/tb_counter_capture_fifo.sv
// Bench for counter_capture_fifo: directed sequences, a per-cycle vector table
// and randomized traffic, all compared against a queue-based reference model.
module tb_counter_capture_fifo;
    import counter_cap_pkg::*;

    localparam int CNT_W = 32;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             p_reset;
    logic [CNT_W-1:0] cnt_in;
    logic             evt_in;
    logic [1:0]       edge_sel;
    logic [LVL_W-1:0] fifo_level;
    logic             ovf_sticky;
    logic             ovf_clr;

    always #5 clk = ~clk;

    counter_capture_fifo_if #(.CNT_W(CNT_W)) cap_if ();

    counter_capture_fifo #(
        .CNT_W       (CNT_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .p_reset    (p_reset),
        .cnt_in     (cnt_in),
        .evt_in     (evt_in),
        .edge_sel   (edge_sel),
        .cap        (cap_if),
        .fifo_level (fifo_level),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: event samples per edge, edges since reset, stored timestamps.
    bit               zq[$];
    int               since_rst = 0;
    logic [CNT_W-1:0] mq[$];
    bit               m_ovf = 1'b0;

    typedef struct {
        bit       evt;
        bit [1:0] sel;
        bit       ready;
        int       exp_level;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_edge();
        bit det;
        bit s;
        bit p;
        bit pop;
        bit push;
        int n;
        det = 1'b0;
        n   = zq.size();
        if (!p_reset && since_rst >= S + 1 && n >= S + 1) begin
            s   = zq[n-S];
            p   = zq[n-S-1];
            det = (edge_sel[0] && s && !p) || (edge_sel[1] && !s && p);
        end
        zq.push_back(p_reset ? 1'b0 : evt_in);
        if (p_reset) begin
            mq.delete();
            m_ovf     = 1'b0;
            since_rst = 0;
        end else begin
            pop  = (mq.size() > 0) && cap_if.cap_ready;
            push = det && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(cnt_in);
            if (det && !push) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (since_rst < S + 1) since_rst++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cnt_in = cnt_in + 1;
        check("model_valid", cap_if.cap_valid, mq.size() > 0);
        check("model_level", fifo_level, mq.size());
        check("model_ovf", ovf_sticky, m_ovf);
        if (mq.size() > 0) check("model_data", cap_if.cap_data, mq[0]);
    endtask

    initial begin
        vec_t             vecs[24];
        logic [CNT_W-1:0] got[$];
        logic [CNT_W-1:0] exp_ts[$];
        logic [CNT_W-1:0] c0;
        logic [CNT_W-1:0] d;
        int               rdy_pct;

        vecs[0]  = '{1, 2'b01, 0, 0};
        vecs[1]  = '{1, 2'b01, 0, 0};
        vecs[2]  = '{1, 2'b01, 0, 1};
        vecs[3]  = '{0, 2'b01, 0, 1};
        vecs[4]  = '{0, 2'b01, 0, 1};
        vecs[5]  = '{0, 2'b01, 0, 1};
        vecs[6]  = '{1, 2'b10, 0, 1};
        vecs[7]  = '{1, 2'b10, 0, 1};
        vecs[8]  = '{0, 2'b10, 0, 1};
        vecs[9]  = '{0, 2'b10, 0, 1};
        vecs[10] = '{0, 2'b10, 0, 2};
        vecs[11] = '{1, 2'b00, 0, 2};
        vecs[12] = '{1, 2'b00, 0, 2};
        vecs[13] = '{1, 2'b00, 0, 2};
        vecs[14] = '{0, 2'b11, 0, 2};
        vecs[15] = '{0, 2'b11, 0, 2};
        vecs[16] = '{0, 2'b11, 0, 3};
        vecs[17] = '{1, 2'b00, 0, 3};
        vecs[18] = '{1, 2'b00, 0, 3};
        vecs[19] = '{1, 2'b01, 0, 4};
        vecs[20] = '{1, 2'b01, 1, 3};
        vecs[21] = '{1, 2'b01, 1, 2};
        vecs[22] = '{1, 2'b01, 1, 1};
        vecs[23] = '{1, 2'b01, 1, 0};

        p_reset          = 1'b1;
        evt_in           = 1'b1;
        edge_sel         = EDGE_RISE;
        cap_if.cap_ready = 1'b0;
        ovf_clr          = 1'b0;
        cnt_in           = '0;

        // Reset state, then release with the event already high.
        repeat (3) tick();
        check("rst_valid", cap_if.cap_valid, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", ovf_sticky, 1'b0);
        check("rst_data", cap_if.cap_data, 0);
        p_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("arm_valid", cap_if.cap_valid, 1'b0);
            check("arm_level", fifo_level, 0);
        end
        evt_in = 1'b0;
        repeat (4) tick();

        // Single rising capture: latency and timestamp.
        cnt_in = 32'h100;
        repeat (3) tick();
        evt_in = 1'b1;
        repeat (2) begin
            tick();
            check("lat_early_valid", cap_if.cap_valid, 1'b0);
        end
        tick();
        check("lat_valid", cap_if.cap_valid, 1'b1);
        check("lat_data", cap_if.cap_data, 32'h105);
        check("lat_level", fifo_level, 1);
        cap_if.cap_ready = 1'b1;
        tick();
        cap_if.cap_ready = 1'b0;
        check("lat_drained", fifo_level, 0);
        evt_in = 1'b0;
        repeat (4) tick();

        // Both edges of a 5-cycle pulse, drained as they arrive.
        edge_sel         = EDGE_BOTH;
        cap_if.cap_ready = 1'b1;
        c0               = cnt_in;
        evt_in           = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) evt_in = 1'b0;
            tick();
            if (cap_if.cap_valid) got.push_back(cap_if.cap_data);
        end
        check("both_count", got.size(), 2);
        if (got.size() == 2) begin
            d = got[1] - got[0];
            check("both_diff", d, 5);
            check("both_first", got[0], c0 + S);
        end

        // Six rising events into a stalled FIFO: overflow and ordering.
        edge_sel         = EDGE_RISE;
        cap_if.cap_ready = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            exp_ts.push_back(cnt_in + S);
            evt_in = 1'b1;
            repeat (2) tick();
            evt_in = 1'b0;
            repeat (2) tick();
        end
        repeat (3) tick();
        check("full_level", fifo_level, DEPTH);
        check("full_ovf", ovf_sticky, 1'b1);
        check("full_head", cap_if.cap_data, exp_ts[0]);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf_sticky, 1'b0);

        // Full FIFO: detection coincides with a pop.
        c0     = cnt_in + S;
        evt_in = 1'b1;
        repeat (S) tick();
        cap_if.cap_ready = 1'b1;
        tick();
        cap_if.cap_ready = 1'b0;
        check("swap_level", fifo_level, DEPTH);
        check("swap_ovf", ovf_sticky, 1'b0);
        check("swap_head", cap_if.cap_data, exp_ts[1]);
        evt_in = 1'b0;
        repeat (3) tick();
        exp_ts[0] = exp_ts[1];
        exp_ts[1] = exp_ts[2];
        exp_ts[2] = exp_ts[3];
        exp_ts[3] = c0;
        cap_if.cap_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain_%0d", j), cap_if.cap_data, exp_ts[j]);
            tick();
        end
        cap_if.cap_ready = 1'b0;
        check("drain_empty", fifo_level, 0);

        // Reset with three entries stored, event rising around the release.
        for (int i = 0; i < 3; i++) begin
            evt_in = 1'b1;
            repeat (2) tick();
            evt_in = 1'b0;
            repeat (2) tick();
        end
        repeat (3) tick();
        check("pre_rst_level", fifo_level, 3);
        evt_in  = 1'b1;
        p_reset = 1'b1;
        tick();
        p_reset = 1'b0;
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_valid", cap_if.cap_valid, 1'b0);
        check("mid_rst_ovf", ovf_sticky, 1'b0);
        for (int i = 0; i < S + 3; i++) begin
            tick();
            check("post_rst_quiet", cap_if.cap_valid, 1'b0);
        end

        // Per-cycle vector table: edge selection including same-cycle changes.
        evt_in = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 24; i++) begin
            evt_in           = vecs[i].evt;
            edge_sel         = vecs[i].sel;
            cap_if.cap_ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
            check($sformatf("vec%0d_valid", i), cap_if.cap_valid, vecs[i].exp_level > 0);
            check($sformatf("vec%0d_ovf", i), ovf_sticky, 1'b0);
        end

        // Randomized traffic against the model, including counter wrap.
        rdy_pct = 70;
        for (int i = 0; i < 2500; i++) begin
            if (i % 100 == 0) rdy_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 3) == 0) evt_in = ~evt_in;
            if ($urandom_range(0, 19) == 0) edge_sel = 2'($urandom_range(0, 3));
            cap_if.cap_ready = ($urandom_range(0, 99) < rdy_pct);
            ovf_clr          = ($urandom_range(0, 14) == 0);
            p_reset          = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 399) == 0) cnt_in = 32'hFFFF_FFF0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
